// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester IDLE/ACCESS/RESP sequencer for a single-port word memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise req0 has fixed priority.
module mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              gnt,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              rw_q, rw_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              win;
    logic              resp_rd;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;   // index of the last winner

    always_comb begin
        if (req0 && req1) begin
            win = ~ptr_q;
        end else begin
            win = ~req0;
        end
    end
`else
    assign win = ~req0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rw_d        = rw_q;
        mem_rw_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d       = win;
                    rw_d        = win ? rw1 : rw0;
                    mem_rw_d    = win ? rw1 : rw0;
                    mem_addr_d  = win ? addr1 : addr0;
                    mem_wdata_d = win ? wdata1 : wdata0;
                    state_d     = ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    ptr_d       = win;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                if (!rw_q) begin
                    if (gnt_q) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            rw_q        <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q       <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rw_q        <= rw_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    // Read data arrives during RESP, so it is forwarded while ack is high and held afterwards.
    assign resp_rd   = (state_q == RESP) && !rw_q;
    assign ack0      = (state_q == RESP) && !gnt_q;
    assign ack1      = (state_q == RESP) && gnt_q;
    assign rdata0    = (resp_rd && !gnt_q) ? mem_rdata : rdata0_q;
    assign rdata1    = (resp_rd && gnt_q) ? mem_rdata : rdata1_q;
    assign busy      = (state_q != IDLE);
    assign gnt       = gnt_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic against a transaction-level model of mem_arbiter,
// with a behavioural 16x32 memory (registered read) attached to the memory port.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, rw0, rw1;
    logic [3:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, busy, gnt, mem_rw;
    logic [31:0] rdata0, rdata1;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .gnt(gnt), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment memory: write on RW, registered read of the presented address.
    logic [31:0] env_mem [16];
    logic [31:0] pre [16];
    logic        do_preload;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= pre[i];
        end else if (mem_rw) begin
            env_mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= env_mem[mem_addr];
    end

    typedef struct packed {
        logic        rw;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    logic [31:0] ref_mem [16];
    logic [31:0] held [2];
    logic [3:0]  m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    txn_t        cur;
    int          g, w, cyc;
    int          checks, errors;
    int          acks [2];
    int          ack_port_q[$];
    int          ack_cyc_q[$];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    int          last_win;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic rw, input logic [3:0] a, input logic [31:0] d);
        txn_t t;
        t.rw = rw; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return mk(r[0], r[4:1], r[63:32]);
    endfunction

    task automatic model_reset();
        g = -100;
        m_addr = '0;
        m_wdata = '0;
        m_gnt = 1'b0;
        held[0] = '0;
        held[1] = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_win = 1;
`endif
    endtask

    task automatic drive_inputs();
        logic [63:0] r;
        r = {$urandom, $urandom};
        if (q0.size() != 0) begin
            req0 = 1'b1; {rw0, addr0, wdata0} = q0[0];
        end else begin
            req0 = 1'b0; {rw0, addr0, wdata0} = r[36:0];
        end
        r = {$urandom, $urandom};
        if (q1.size() != 0) begin
            req1 = 1'b1; {rw1, addr1, wdata1} = q1[0];
        end else begin
            req1 = 1'b0; {rw1, addr1, wdata1} = r[36:0];
        end
    endtask

    // One clock cycle: check this cycle's outputs, apply closing-edge effects, drive next inputs.
    task automatic step(input logic r);
        int          ph;
        logic [31:0] e_rd [2];
        @(negedge clk);
        cyc++;
        ph = cyc - g;
        e_rd[0] = held[0];
        e_rd[1] = held[1];
        if (ph == 2 && !cur.rw) e_rd[w] = ref_mem[cur.addr];
        chk("ack0",      32'(ack0),      32'(ph == 2 && w == 0));
        chk("ack1",      32'(ack1),      32'(ph == 2 && w == 1));
        chk("busy",      32'(busy),      32'(ph == 1 || ph == 2));
        chk("gnt",       32'(gnt),       32'(m_gnt));
        chk("mem_rw",    32'(mem_rw),    32'(ph == 1 && cur.rw));
        chk("mem_addr",  32'(mem_addr),  32'(m_addr));
        chk("mem_wdata", mem_wdata,      m_wdata);
        chk("rdata0",    rdata0,         e_rd[0]);
        chk("rdata1",    rdata1,         e_rd[1]);
        if (ph == 1 && cur.rw) ref_mem[cur.addr] = cur.wdata;
        if (ph == 2) begin
            held[w] = e_rd[w];
            acks[w]++;
            ack_port_q.push_back(w);
            ack_cyc_q.push_back(cyc);
            if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (r) begin
            if (ph == 1) begin
                if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            model_reset();
        end
        rst = r;
        drive_inputs();
        if (!r && ph >= 3 && (req0 || req1)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (req0 && req1) w = (last_win == 0) ? 1 : 0;
            else w = req0 ? 0 : 1;
            last_win = w;
`else
            w = req0 ? 0 : 1;
`endif
            cur = (w == 0) ? q0[0] : q1[0];
            g = cyc;
            m_addr = cur.addr;
            m_wdata = cur.wdata;
            m_gnt = (w == 1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            step(1'b0);
            n++;
        end
        chk("drain_done", 32'(q0.size() + q1.size()), 32'd0);
        step(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, exp_a[3], exp_b[2];
        checks = 0; errors = 0; cyc = 0;
        acks[0] = 0; acks[1] = 0;
        rst = 1'b1; do_preload = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 16; i++) begin
            pre[i] = $urandom;
            ref_mem[i] = pre[i];
        end
        model_reset();
        repeat (2) @(negedge clk);
        do_preload = 1'b0;
        step(1'b1);
        step(1'b0);

        // Write 42 to address 1 from requester 0, then read it back on requester 1.
        q0.push_back(mk(1'b1, 4'd1, 32'd42));
        drain();
        chk("wr_ack0_count", 32'(acks[0]), 32'd1);
        chk("wr_ack1_count", 32'(acks[1]), 32'd0);
        q1.push_back(mk(1'b0, 4'd1, 32'd0));
        drain();
        chk("rd1_after_wr", rdata1, 32'd42);

        // Simultaneous requests; requester 0 re-presents at its ack in round A.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_a = '{0, 1, 0};
        exp_b = '{1, 0};
`else
        exp_a = '{0, 0, 1};
        exp_b = '{0, 1};
`endif
        ack_port_q.delete();
        q0.push_back(mk(1'b0, 4'd3, 32'd0));
        q0.push_back(mk(1'b0, 4'd5, 32'd0));
        q1.push_back(mk(1'b0, 4'd4, 32'd0));
        drain();
        chk("orderA_len", 32'(ack_port_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < ack_port_q.size(); i++)
            chk($sformatf("orderA_%0d", i), 32'(ack_port_q[i]), 32'(exp_a[i]));
        ack_port_q.delete();
        q0.push_back(mk(1'b0, 4'd3, 32'd0));
        q1.push_back(mk(1'b0, 4'd4, 32'd0));
        drain();
        chk("orderB_len", 32'(ack_port_q.size()), 32'd2);
        for (int i = 0; i < 2 && i < ack_port_q.size(); i++)
            chk($sformatf("orderB_%0d", i), 32'(ack_port_q[i]), 32'(exp_b[i]));

        // Reset during the ACCESS cycle of a write: it commits, but is never acked.
        a0 = acks[0];
        q0.push_back(mk(1'b1, 4'd7, 32'hDEADBEEF));
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("rst_no_ack", 32'(acks[0]), 32'(a0));
        q1.push_back(mk(1'b0, 4'd7, 32'd0));
        drain();
        chk("rd7_after_rst", rdata1, 32'hDEADBEEF);

        // Back-to-back reads of every address with req0 held across each ack.
        a0 = acks[0];
        ack_cyc_q.delete();
        for (int i = 0; i < 16; i++) q0.push_back(mk(1'b0, 4'(i), 32'd0));
        drain();
        chk("seq_ack_count", 32'(acks[0] - a0), 32'd16);
        if (ack_cyc_q.size() == 16)
            chk("seq_span", 32'(ack_cyc_q[15] - ack_cyc_q[0]), 32'd45);
        else
            chk("seq_ack_log", 32'(ack_cyc_q.size()), 32'd16);

        // Requester 1 only.
        a0 = acks[0];
        a1 = acks[1];
        for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, 4'(i + 8), 32'd0));
        drain();
        chk("r1only_ack0", 32'(acks[0] - a0), 32'd0);
        chk("r1only_ack1", 32'(acks[1] - a1), 32'd4);
        chk("r1only_gnt", 32'(gnt), 32'd1);

        // Random mixed traffic.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 3) q0.push_back(rnd_txn());
            if ($urandom_range(0, 2) == 0 && q1.size() < 3) q1.push_back(rnd_txn());
            step(1'b0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
